// File: rtl/seg7_scan_decoder_if.sv
// Snoop-side view of a scanned 7-segment display bus plus the decoded frame.
// The display driver (or pin model) is the master; the decoder is the slave.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] value_out;
    logic [NUM_DIGITS-1:0]   err_mask;
    logic                    frame_valid;

    modport master (
        output seg_in, an_in,
        input  value_out, err_mask, frame_valid
    );

    modport slave (
        input  seg_in, an_in,
        output value_out, err_mask, frame_valid
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a time-multiplexed active-low 7-segment bus,
// debounces each digit dwell, maps glyphs back to nibbles and publishes a
// complete multi-digit value once every digit has been seen.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_decoder_if.slave bus
);
    localparam logic [7:0]            STABLE = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ONE    = NUM_DIGITS'(1);

    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_cnt;
    logic                    r_done;
    logic [4*NUM_DIGITS-1:0] r_slots;
    logic [NUM_DIGITS-1:0]   r_cap;
    logic [NUM_DIGITS-1:0]   r_errp;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_err_mask;
    logic                    r_fv;

    logic                    w_same;
    logic [7:0]              w_cnt_nxt;
    logic                    w_dwell;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_onehot;
    logic                    w_blank;
    logic [3:0]              w_nib;
    logic                    w_known;
    logic                    w_commit;
    logic                    w_frame_done;
    logic [NUM_DIGITS-1:0]   w_cap_nxt;
    logic [NUM_DIGITS-1:0]   w_errp_nxt;
    logic [4*NUM_DIGITS-1:0] w_slots_nxt;

    // Glyph table inverse: segment pattern back to a hex nibble
    always_comb begin
        w_nib   = 4'h0;
        w_known = 1'b1;
        case (bus.seg_in)
            7'b0000001: w_nib = 4'h0;
            7'b1001111: w_nib = 4'h1;
            7'b0010010: w_nib = 4'h2;
            7'b0000110: w_nib = 4'h3;
            7'b1001100: w_nib = 4'h4;
            7'b0100100: w_nib = 4'h5;
            7'b0100000: w_nib = 4'h6;
            7'b0001111: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0000100: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b1100000: w_nib = 4'hB;
            7'b0110001: w_nib = 4'hC;
            7'b1000010: w_nib = 4'hD;
            7'b0110000: w_nib = 4'hE;
            7'b0111000: w_nib = 4'hF;
            default:    w_known = 1'b0;
        endcase
    end

    // Dwell tracking: the incoming pair is compared against the last sample,
    // so the commit edge is the STABLE_CYCLES-th edge seeing the same pair
    always_comb begin
        w_same       = ({bus.seg_in, bus.an_in} == {r_seg, r_an});
        w_cnt_nxt    = !w_same ? 8'd1 : ((r_cnt == STABLE) ? STABLE : r_cnt + 8'd1);
        w_dwell      = (w_cnt_nxt == STABLE) && !r_done;
        w_sel        = ~bus.an_in;
        w_onehot     = (w_sel != '0) && ((w_sel & (w_sel - ONE)) == '0);
        w_blank      = (bus.seg_in == '1);
        w_commit     = w_dwell && w_onehot && !w_blank;
        w_frame_done = &r_cap;
    end

    // Frame assembly: completion clears the frame first, a same-edge commit
    // then lands in the fresh frame
    always_comb begin
        w_cap_nxt   = w_frame_done ? '0 : r_cap;
        w_errp_nxt  = w_frame_done ? '0 : r_errp;
        w_slots_nxt = r_slots;
        if (w_commit) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (w_sel[i]) begin
                    w_cap_nxt[i]          = 1'b1;
                    w_errp_nxt[i]         = ~w_known;
                    w_slots_nxt[4*i +: 4] = w_nib;
                end
            end
        end
    end

    // Input sampling and stability counter; a dwell is consumed even when
    // it does not commit (idle, illegal enables, blank)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg  <= '1;
            r_an   <= '1;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_seg  <= bus.seg_in;
            r_an   <= bus.an_in;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_same ? (r_done | w_dwell) : 1'b0;
        end
    end

    // Capture state and published frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slots    <= '0;
            r_cap      <= '0;
            r_errp     <= '0;
            r_value    <= '0;
            r_err_mask <= '0;
            r_fv       <= 1'b0;
        end else begin
            r_slots <= w_slots_nxt;
            r_cap   <= w_cap_nxt;
            r_errp  <= w_errp_nxt;
            r_fv    <= w_frame_done;
            if (w_frame_done) begin
                r_value    <= r_slots;
                r_err_mask <= r_errp;
            end
        end
    end

    assign bus.value_out   = r_value;
    assign bus.err_mask    = r_err_mask;
    assign bus.frame_valid = r_fv;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: dwell-level reference model feeding a
// scoreboard queue, monitor pops on every frame_valid pulse.
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int S  = 8;
    localparam logic [6:0]    BLANK   = 7'h7F;
    localparam logic [ND-1:0] AN_IDLE = '1;

    typedef struct {
        logic [4*ND-1:0] v;
        logic [ND-1:0]   e;
        int unsigned     at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_fail = 0;
    int frames_seen = 0;
    logic [4*ND-1:0] last_v = '0;
    logic [ND-1:0]   last_e = '0;

    exp_t exp_q[$];

    logic [6:0]    glyph [16];
    logic [3:0]    m_slot [ND];
    logic [ND-1:0] m_cap, m_err;
    logic [6:0]    cur_seg;
    logic [ND-1:0] cur_an;
    int unsigned   cur_start;
    bit            cur_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: a digit dwell that lasts at least S edges commits once
    function automatic void model_commit(input logic [6:0] seg, input logic [ND-1:0] an,
                                         input int unsigned at);
        int   lows;
        int   idx;
        int   nib;
        exp_t x;
        lows = 0;
        idx  = 0;
        nib  = -1;
        for (int i = 0; i < ND; i++) if (!an[i]) begin lows++; idx = i; end
        if (lows != 1 || seg == BLANK) return;
        for (int g = 0; g < 16; g++) if (glyph[g] == seg) nib = g;
        m_slot[idx] = (nib < 0) ? 4'h0 : 4'(nib);
        m_err[idx]  = (nib < 0);
        m_cap[idx]  = 1'b1;
        if (&m_cap) begin
            x.v = '0;
            for (int i = 0; i < ND; i++) x.v[4*i +: 4] = m_slot[i];
            x.e  = m_err;
            x.at = at + 1;
            exp_q.push_back(x);
            m_cap = '0;
            m_err = '0;
        end
    endfunction

    // Hold one (seg, an) pair for len edges; entered and left just after an edge
    task automatic dwell(input logic [6:0] seg, input logic [ND-1:0] an, input int unsigned len);
        int unsigned start;
        start = edge_n + 1;
        bus.seg_in = seg;
        bus.an_in  = an;
        if (seg != cur_seg || an != cur_an) begin
            cur_seg   = seg;
            cur_an    = an;
            cur_start = start;
            cur_done  = 1'b0;
        end
        if (!cur_done && (start + len - cur_start) >= S) begin
            cur_done = 1'b1;
            model_commit(seg, an, cur_start + S - 1);
        end
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned cycles);
        bus.seg_in = BLANK;
        bus.an_in  = AN_IDLE;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cap    = '0;
        m_err    = '0;
        cur_seg  = BLANK;
        cur_an   = AN_IDLE;
        cur_done = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_value"}, 32'(bus.value_out), 32'h0);
        check({tag, "_err"},   32'(bus.err_mask), 32'h0);
        check({tag, "_fv"},    32'(bus.frame_valid), 32'h0);
    endtask

    task automatic drain();
        dwell(BLANK, AN_IDLE, S + 4);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n && bus.frame_valid) begin
            frames_seen++;
            last_v = bus.value_out;
            last_e = bus.err_mask;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame actual value=%0h err=%b required none",
                         bus.value_out, bus.err_mask);
            end else begin
                x = exp_q.pop_front();
                check("frame_value", 32'(bus.value_out), 32'(x.v));
                check("frame_err",   32'(bus.err_mask),  32'(x.e));
                check("frame_edge",  edge_n, x.at);
            end
        end
    end

    int          f0;
    logic [6:0]  s;
    logic [ND-1:0] a;
    int unsigned r;

    initial begin
        glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        for (int i = 0; i < ND; i++) m_slot[i] = 4'h0;

        do_reset(3);
        check_reset_state("reset");

        // Basic scan 1,2,3,4
        f0 = frames_seen;
        dwell(glyph[1], 4'b0111, 10);
        dwell(glyph[2], 4'b1011, 10);
        dwell(glyph[3], 4'b1101, 10);
        dwell(glyph[4], 4'b1110, 10);
        drain();
        check("t1_frames", 32'(frames_seen - f0), 32'd1);
        check("t1_value",  32'(last_v), 32'h1234);
        check("t1_err",    32'(last_e), 32'h0);

        // Short glitch dwell of E before the real 1 on digit 0
        f0 = frames_seen;
        dwell(glyph[5], 4'b0111, 10);
        dwell(glyph[6], 4'b1011, 10);
        dwell(glyph[7], 4'b1101, 10);
        dwell(glyph[14], 4'b1110, 5);
        dwell(glyph[1], 4'b1110, 10);
        drain();
        check("t2_frames", 32'(frames_seen - f0), 32'd1);
        check("t2_value",  32'(last_v), 32'h5671);

        // Unknown glyph on digit 2, then a clean scan
        dwell(glyph[8], 4'b0111, 10);
        dwell(7'b1111110, 4'b1011, 10);
        dwell(glyph[8], 4'b1101, 10);
        dwell(glyph[8], 4'b1110, 10);
        drain();
        check("t3_value", 32'(last_v), 32'h8088);
        check("t3_err",   32'(last_e), 32'b0100);
        for (int d = ND - 1; d >= 0; d--) dwell(glyph[8], ~(ND'(1) << d), 10);
        drain();
        check("t3b_value", 32'(last_v), 32'h8888);
        check("t3b_err",   32'(last_e), 32'h0);

        // Illegal enables, blank and idle dwells interleaved
        f0 = frames_seen;
        dwell(glyph[10], 4'b0111, 10);
        dwell(glyph[12], 4'b0011, 10);
        dwell(glyph[11], 4'b1011, 10);
        dwell(BLANK,     4'b1101, 10);
        dwell(glyph[12], 4'b1101, 10);
        dwell(glyph[8],  AN_IDLE, 10);
        dwell(glyph[13], 4'b1110, 10);
        drain();
        check("t4_frames", 32'(frames_seen - f0), 32'd1);
        check("t4_value",  32'(last_v), 32'hABCD);

        // Long dwell commits once and does not complete a frame by itself
        f0 = frames_seen;
        dwell(glyph[3], 4'b1101, 40);
        drain();
        check("t5_noframe", 32'(frames_seen - f0), 32'd0);
        dwell(glyph[5], 4'b0111, 10);
        dwell(glyph[6], 4'b1011, 10);
        dwell(glyph[7], 4'b1110, 10);
        drain();
        check("t5_frames", 32'(frames_seen - f0), 32'd1);
        check("t5_value",  32'(last_v), 32'h5637);

        // Reset after three digits discards the partial frame
        f0 = frames_seen;
        dwell(glyph[9],  4'b0111, 10);
        dwell(glyph[10], 4'b1011, 10);
        dwell(glyph[11], 4'b1101, 10);
        dwell(BLANK, AN_IDLE, 3);
        do_reset(1);
        check_reset_state("midrst");
        dwell(glyph[12], 4'b1110, 10);
        drain();
        check("t6_noframe", 32'(frames_seen - f0), 32'd0);
        dwell(glyph[15], 4'b0111, 10);
        dwell(glyph[14], 4'b1011, 10);
        dwell(glyph[13], 4'b1101, 10);
        drain();
        check("t6_frames", 32'(frames_seen - f0), 32'd1);
        check("t6_value",  32'(last_v), 32'hFEDC);

        // Randomized dwells
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      a = ~(ND'(1) << $urandom_range(0, ND - 1));
            else if (r < 90) a = AN_IDLE;
            else             a = ND'($urandom);
            r = $urandom_range(0, 99);
            if (r < 75)      s = glyph[$urandom_range(0, 15)];
            else if (r < 85) s = BLANK;
            else             s = 7'($urandom);
            dwell(s, a, $urandom_range(1, S + 5));
            if ($urandom_range(0, 49) == 0) begin
                dwell(BLANK, AN_IDLE, 3);
                do_reset($urandom_range(1, 3));
                check_reset_state("rnd_rst");
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
